fre_scan_ctrl: RTL and testbench
================================

FRE_SCAN_CTRL -- requirements
Module: fre_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PHASE_WIDTH, default 32, giving the tuning-word width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 12, giving the signed I/Q sample width.
REQ-003 The block SHALL have parameter SETTLE_SAMPLES, default 4, giving the number of decimated samples discarded after each retune (minimum 1).
REQ-004 The block SHALL have parameter AVG_LOG2, default 3, so that 2^AVG_LOG2 samples are averaged per step.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below.
- clk_in  in  1  sole clock
- RST_N  in  1  asynchronous active-low reset
- start  in  1  scan request pulse
- abort  in  1  cancel scan
- f_start  in  PHASE_WIDTH  first tuning word
- f_step  in  PHASE_WIDTH  tuning increment
- n_steps  in  16  number of channels (0 treated as 1)
- sample_valid  in  1  one-cycle strobe per decimated mixer output
- I_in, Q_in  in  DATA_WIDTH  signed decimated I/Q
- Fre_word  out  PHASE_WIDTH  tuning word to mixer LO
- busy  out  1  scan in progress
- done  out  1  one-cycle completion pulse
- peak_valid  out  1  peak outputs hold a completed scan
- peak_word  out  PHASE_WIDTH  tuning word of strongest channel
- peak_mag  out  DATA_WIDTH+1  averaged magnitude of strongest channel
- peak_idx  out  16  step index of strongest channel

Function
REQ-006 The FSM SHALL have the states IDLE, TUNE, SETTLE, MEASURE, COMPARE and DONE; busy SHALL be high in every state except IDLE.
REQ-007 In IDLE, when start=1 and abort=0, the block SHALL latch f_start, f_step and n_steps, clear idx, peak_mag and peak_valid, and go to TUNE.
REQ-008 In TUNE, the block SHALL drive Fre_word with the current word, clear the sample counter, and go to SETTLE after 1 cycle.
REQ-009 In SETTLE, the block SHALL count sample_valid strobes and go to MEASURE on the SETTLE_SAMPLES-th strobe; those samples SHALL NOT be accumulated.
REQ-010 In MEASURE, on each strobe the block SHALL add |I_in|+|Q_in| into an accumulator of DATA_WIDTH+1+AVG_LOG2 bits.
- |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1), held unsigned, with no saturation.
- After 2^AVG_LOG2 strobes the block SHALL go to COMPARE.
REQ-011 COMPARE SHALL last 1 cycle and SHALL form mag = acc >> AVG_LOG2.
- If mag > peak_mag (strict compare, so ties keep the earliest index), it SHALL load peak_mag, peak_word and peak_idx from the current step.
REQ-012 From COMPARE, if idx = max(n_steps,1)-1 the block SHALL go to DONE; otherwise it SHALL increment idx, set Fre_word to Fre_word+f_step modulo 2^PHASE_WIDTH, and go to TUNE.
REQ-013 DONE SHALL last 1 cycle: done=1, peak_valid set to 1, Fre_word loaded with peak_word (the LO parks on the best channel), then IDLE.
REQ-014 sample_valid strobes in IDLE, TUNE, COMPARE and DONE SHALL be ignored.
REQ-015 start while busy SHALL be ignored.
REQ-016 abort in any non-IDLE state SHALL force IDLE on the next edge.
- No done pulse, peak_valid stays 0, and Fre_word holds its last value.
- abort together with start in IDLE SHALL leave the block in IDLE.
REQ-017 The first peak at step 0 SHALL always be captured when its mag > 0; an all-zero scan SHALL report peak_idx=0, peak_word=f_start, peak_mag=0.

Reset
REQ-018 RST_N=0 SHALL immediately and asynchronously force state IDLE and clear every register and output to 0 (Fre_word, busy, done, peak_*).
REQ-019 Release of RST_N SHALL take effect on the next clk_in edge, and reset mid-scan SHALL discard all scan progress.

Structure
REQ-020 The state encoding, the default parameter values and the magnitude/accumulator width expressions SHALL live in shared package fre_scan_pkg.
REQ-021 The |I|+|Q| computation SHALL be a combinational sub-module iq_abs_sum; all state SHALL live in fre_scan_ctrl.

Verification
REQ-022 Peak search: f_start=0x1000_0000, f_step=0x0100_0000, n_steps=4, Q=0, I=100/300/200/50 per step -> done after 48 strobes, peak_idx=1, peak_word=0x1100_0000, peak_mag=300, Fre_word=0x1100_0000.
REQ-023 Tie: n_steps=2, I=500 on both steps -> peak_idx=0, peak_mag=500.
REQ-024 Wrap: f_start=0xFF00_0000, f_step=0x0100_0000, n_steps=3 -> TUNE words are 0xFF00_0000, 0x0000_0000, 0x0100_0000.
REQ-025 Extremes: I=Q=-2048 constant -> peak_mag=4096 with no overflow.
REQ-026 Abort during MEASURE of step 2 -> busy=0 next cycle, done never pulses, peak_valid=0, and a following start runs a clean scan.
REQ-027 RST_N low mid-SETTLE -> all outputs 0 without a clock edge, and the block is IDLE after release.

Source files
------------

// File: rtl/fre_scan_pkg.sv
// Shared definitions for the frequency-scan controller: FSM state encoding,
// default parameter values and the magnitude/accumulator width rules.
package fre_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TUNE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } scan_state_e;

    localparam int DEF_PHASE_WIDTH    = 32;
    localparam int DEF_DATA_WIDTH     = 12;
    localparam int DEF_SETTLE_SAMPLES = 4;
    localparam int DEF_AVG_LOG2       = 3;

    // |I|+|Q| of two signed DW-bit samples needs one extra bit.
    function automatic int mag_width(input int dw);
        return dw + 1;
    endfunction

    // Summing 2^al magnitudes needs al further bits, so the sum never wraps.
    function automatic int acc_width(input int dw, input int al);
        return dw + 1 + al;
    endfunction

endpackage

// File: rtl/iq_abs_sum.sv
// Combinational |I|+|Q| of one signed I/Q sample pair. The most negative
// input maps to 2^(DATA_WIDTH-1), which fits unsigned in DATA_WIDTH bits.
module iq_abs_sum
    import fre_scan_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] i_val,
    input  logic signed [DATA_WIDTH-1:0] q_val,
    output logic        [DATA_WIDTH:0]   abs_sum
);

    logic [DATA_WIDTH-1:0] abs_i;
    logic [DATA_WIDTH-1:0] abs_q;

    // Two's-complement negate of negative samples, read back as unsigned.
    always_comb begin
        abs_i   = i_val[DATA_WIDTH-1] ? (~i_val + 1'b1) : i_val;
        abs_q   = q_val[DATA_WIDTH-1] ? (~q_val + 1'b1) : q_val;
        abs_sum = {1'b0, abs_i} + {1'b0, abs_q};
    end

endmodule

// File: rtl/fre_scan_ctrl.sv
// Frequency-scan controller: steps the mixer LO across n_steps channels,
// discards settling samples after each retune, averages |I|+|Q| per channel
// and parks the LO on the strongest channel at the end of the scan.
module fre_scan_ctrl
    import fre_scan_pkg::*;
#(
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    parameter int AVG_LOG2       = DEF_AVG_LOG2
) (
    input  logic                         clk_in,
    input  logic                         RST_N,
    input  logic                         start,
    input  logic                         abort,
    input  logic [PHASE_WIDTH-1:0]       f_start,
    input  logic [PHASE_WIDTH-1:0]       f_step,
    input  logic [15:0]                  n_steps,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] I_in,
    input  logic signed [DATA_WIDTH-1:0] Q_in,
    output logic [PHASE_WIDTH-1:0]       Fre_word,
    output logic                         busy,
    output logic                         done,
    output logic                         peak_valid,
    output logic [PHASE_WIDTH-1:0]       peak_word,
    output logic [DATA_WIDTH:0]          peak_mag,
    output logic [15:0]                  peak_idx
);

    localparam int MAG_W   = mag_width(DATA_WIDTH);
    localparam int ACC_W   = acc_width(DATA_WIDTH, AVG_LOG2);
    localparam int N_AVG   = 1 << AVG_LOG2;
    localparam int CNT_MAX = (SETTLE_SAMPLES > N_AVG) ? SETTLE_SAMPLES : N_AVG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] AVG_LAST    = CNT_W'(N_AVG - 1);

    scan_state_e            state_q, state_d;
    logic [PHASE_WIDTH-1:0] cur_word_q, cur_word_d;
    logic [PHASE_WIDTH-1:0] step_q, step_d;
    logic [15:0]            n_last_q, n_last_d;
    logic [15:0]            idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] fre_word_q, fre_word_d;
    logic [PHASE_WIDTH-1:0] peak_word_q, peak_word_d;
    logic [MAG_W-1:0]       peak_mag_q, peak_mag_d;
    logic [15:0]            peak_idx_q, peak_idx_d;
    logic                   peak_valid_q, peak_valid_d;

    logic [MAG_W-1:0]       abs_sum;
    logic [ACC_W-1:0]       acc_shift;
    logic [MAG_W-1:0]       mag;
    logic                   new_peak;

    iq_abs_sum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_abs (
        .i_val   (I_in),
        .q_val   (Q_in),
        .abs_sum (abs_sum)
    );

    // Average of the current step; the accumulator is wide enough that the
    // shifted value always fits the magnitude width.
    always_comb begin
        acc_shift = acc_q >> AVG_LOG2;
        mag       = acc_shift[MAG_W-1:0];
        new_peak  = (mag > peak_mag_q);
    end

    // Next-state and datapath updates; abort overrides everything but IDLE.
    always_comb begin
        state_d      = state_q;
        cur_word_d   = cur_word_q;
        step_d       = step_q;
        n_last_d     = n_last_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        fre_word_d   = fre_word_q;
        peak_word_d  = peak_word_q;
        peak_mag_d   = peak_mag_q;
        peak_idx_d   = peak_idx_q;
        peak_valid_d = peak_valid_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        cur_word_d   = f_start;
                        step_d       = f_step;
                        n_last_d     = (n_steps == 16'd0) ? 16'd0 : (n_steps - 16'd1);
                        idx_d        = 16'd0;
                        peak_mag_d   = '0;
                        peak_word_d  = f_start;
                        peak_idx_d   = 16'd0;
                        peak_valid_d = 1'b0;
                        state_d      = ST_TUNE;
                    end
                end
                ST_TUNE: begin
                    fre_word_d = cur_word_q;
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (sample_valid) begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_MEASURE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (sample_valid) begin
                        acc_d = acc_q + ACC_W'(abs_sum);
                        if (cnt_q == AVG_LAST) begin
                            state_d = ST_COMPARE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (new_peak) begin
                        peak_mag_d  = mag;
                        peak_word_d = cur_word_q;
                        peak_idx_d  = idx_q;
                    end
                    if (idx_q == n_last_q) begin
                        // Park the LO on the winner, including this step's.
                        fre_word_d   = new_peak ? cur_word_q : peak_word_q;
                        peak_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        idx_d      = idx_q + 16'd1;
                        cur_word_d = cur_word_q + step_q;
                        fre_word_d = cur_word_q + step_q;
                        state_d    = ST_TUNE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cur_word_q   <= '0;
            step_q       <= '0;
            n_last_q     <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            fre_word_q   <= '0;
            peak_word_q  <= '0;
            peak_mag_q   <= '0;
            peak_idx_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_word_q   <= cur_word_d;
            step_q       <= step_d;
            n_last_q     <= n_last_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            fre_word_q   <= fre_word_d;
            peak_word_q  <= peak_word_d;
            peak_mag_q   <= peak_mag_d;
            peak_idx_q   <= peak_idx_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign Fre_word   = fre_word_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign peak_valid = peak_valid_q;
    assign peak_word  = peak_word_q;
    assign peak_mag   = peak_mag_q;
    assign peak_idx   = peak_idx_q;

endmodule

// File: tb/tb_fre_scan_ctrl.sv
// Self-checking bench for fre_scan_ctrl: directed and randomized scans
// against a per-channel average/peak model, plus abort and reset cases.
module tb_fre_scan_ctrl;

    localparam int PW   = 32;
    localparam int DW   = 12;
    localparam int SS   = 4;
    localparam int AL   = 3;
    localparam int NAVG = 1 << AL;
    localparam int SPS  = SS + NAVG;

    logic                 clk_in = 1'b0;
    logic                 RST_N = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [PW-1:0]        f_start = '0;
    logic [PW-1:0]        f_step = '0;
    logic [15:0]          n_steps = '0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] I_in = '0;
    logic signed [DW-1:0] Q_in = '0;
    logic [PW-1:0]        Fre_word;
    logic                 busy;
    logic                 done;
    logic                 peak_valid;
    logic [PW-1:0]        peak_word;
    logic [DW:0]          peak_mag;
    logic [15:0]          peak_idx;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    int step_i[16];
    int step_q[16];
    bit rand_data = 1'b0;

    fre_scan_ctrl #(
        .PHASE_WIDTH    (PW),
        .DATA_WIDTH     (DW),
        .SETTLE_SAMPLES (SS),
        .AVG_LOG2       (AL)
    ) dut (
        .clk_in       (clk_in),
        .RST_N        (RST_N),
        .start        (start),
        .abort        (abort),
        .f_start      (f_start),
        .f_step       (f_step),
        .n_steps      (n_steps),
        .sample_valid (sample_valid),
        .I_in         (I_in),
        .Q_in         (Q_in),
        .Fre_word     (Fre_word),
        .busy         (busy),
        .done         (done),
        .peak_valid   (peak_valid),
        .peak_word    (peak_word),
        .peak_mag     (peak_mag),
        .peak_idx     (peak_idx)
    );

    always #5 clk_in = ~clk_in;

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_fre"},   Fre_word, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_pval"},  peak_valid, 0);
        check({tag, "_pword"}, peak_word, 0);
        check({tag, "_pmag"},  peak_mag, 0);
        check({tag, "_pidx"},  peak_idx, 0);
    endtask

    // Runs one scan. Strobes are spaced so none lands in TUNE/COMPARE, hence
    // strobe j belongs to channel j/SPS and is averaged when j%SPS >= SS.
    // abort_step >= 0 aborts after two averaged strobes of that channel.
    task automatic run_scan(input logic [PW-1:0] fs, input logic [PW-1:0] fst,
                            input int n, input int abort_step);
        int      neff;
        longint  sum_k;
        longint  exp_mag;
        int      exp_idx;
        logic [PW-1:0] exp_word;
        logic [PW-1:0] word_k;
        int      d0;
        int      iv;
        int      qv;
        bit      seen;
        neff     = (n == 0) ? 1 : n;
        d0       = done_cnt;
        exp_mag  = 0;
        exp_idx  = 0;
        exp_word = fs;
        word_k   = fs;

        f_start = fs;
        f_step  = fst;
        n_steps = n[15:0];
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("busy_after_start", busy, 1);
        check("pval_cleared", peak_valid, 0);

        for (int k = 0; k < neff; k++) begin
            sum_k = 0;
            for (int p = 0; p < SPS; p++) begin
                repeat ($urandom_range(2, 4)) tick();
                if (p == 0) check("tune_word", Fre_word, word_k);
                if (k == abort_step && p == SS + 2) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check("abort_busy", busy, 0);
                    check("abort_pval", peak_valid, 0);
                    check("abort_fre_hold", Fre_word, word_k);
                    check("abort_no_done", done_cnt - d0, 0);
                    $display("scan n=%0d aborted at step %0d", n, k);
                    return;
                end
                if (rand_data) begin
                    iv = int'($urandom_range(0, 4095)) - 2048;
                    qv = int'($urandom_range(0, 4095)) - 2048;
                end else begin
                    iv = step_i[k];
                    qv = step_q[k];
                end
                I_in = iv[DW-1:0];
                Q_in = qv[DW-1:0];
                sample_valid = 1'b1;
                // A start mid-scan must be ignored.
                if (p == 1) start = 1'b1;
                tick();
                sample_valid = 1'b0;
                start = 1'b0;
                if (p >= SS) sum_k += iabs(iv) + iabs(qv);
            end
            if (sum_k / NAVG > exp_mag) begin
                exp_mag  = sum_k / NAVG;
                exp_idx  = k;
                exp_word = word_k;
            end
            word_k = word_k + fst;
        end

        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_pulse", seen, 1);
        check("done_busy", busy, 1);
        check("done_fre_park", Fre_word, exp_word);
        tick();
        check("done_width", done, 0);
        check("idle_busy", busy, 0);
        check("peak_valid", peak_valid, 1);
        check("peak_idx", peak_idx, exp_idx);
        check("peak_word", peak_word, exp_word);
        check("peak_mag", peak_mag, exp_mag);
        check("fre_parked", Fre_word, exp_word);
        check("done_count", done_cnt - d0, 1);
        $display("scan n=%0d fs=%08h step=%08h -> idx=%0d word=%08h mag=%0d",
                 n, fs, fst, peak_idx, peak_word, peak_mag);
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        @(negedge clk_in);
        RST_N = 1'b1;
        tick();
        check("post_reset_busy", busy, 0);

        // Strobes in IDLE are ignored; start with abort stays IDLE.
        I_in = 12'sd2047; Q_in = 12'sd2047;
        repeat (3) begin
            sample_valid = 1'b1; tick(); sample_valid = 1'b0; tick();
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);
        tick();
        check("start_abort_idle2", busy, 0);

        // Peak search.
        rand_data = 1'b0;
        step_i[0] = 100; step_i[1] = 300; step_i[2] = 200; step_i[3] = 50;
        for (int k = 0; k < 4; k++) step_q[k] = 0;
        run_scan(32'h1000_0000, 32'h0100_0000, 4, -1);
        check("req_peak_idx", peak_idx, 1);
        check("req_peak_word", peak_word, 32'h1100_0000);
        check("req_peak_mag", peak_mag, 300);

        // Tie keeps earliest step.
        step_i[0] = 500; step_i[1] = 500;
        run_scan(32'h2000_0000, 32'h0000_1000, 2, -1);
        check("tie_idx", peak_idx, 0);

        // Tuning-word wrap.
        step_i[0] = 10; step_i[1] = 20; step_i[2] = 30;
        run_scan(32'hFF00_0000, 32'h0100_0000, 3, -1);

        // Extreme negative samples.
        for (int k = 0; k < 2; k++) begin step_i[k] = -2048; step_q[k] = -2048; end
        run_scan(32'h0000_0100, 32'h0000_0100, 2, -1);
        check("extreme_mag", peak_mag, 4096);

        // All-zero scan reports step 0 / f_start; n_steps=0 acts as 1.
        for (int k = 0; k < 3; k++) begin step_i[k] = 0; step_q[k] = 0; end
        run_scan(32'h1234_5678, 32'h0000_0001, 3, -1);
        run_scan(32'h0ABC_0000, 32'h0000_0010, 0, -1);

        // Randomized scans.
        rand_data = 1'b1;
        for (int r = 0; r < 6; r++)
            run_scan($urandom, $urandom, $urandom_range(0, 5), -1);

        // Abort during MEASURE of step 2, then a clean scan.
        run_scan(32'h4000_0000, 32'h0010_0000, 4, 2);
        run_scan(32'h4000_0000, 32'h0010_0000, 4, -1);

        // Asynchronous reset mid-SETTLE.
        f_start = 32'h5555_0000; f_step = 32'h1; n_steps = 16'd3;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        check("pre_reset_busy", busy, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk_in);
        RST_N = 1'b1;
        tick();
        check("rst_release_idle", busy, 0);
        run_scan(32'h0000_0000, 32'h0800_0000, 3, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
